// File: rtl/switch_event_gen.sv
// Turns debounced switch levels into registered press/release pulses with optional
// hold-to-repeat, one independent three-state FSM per switch channel.
module switch_event_gen #(
  parameter int NUM_SW        = 4,
  parameter int REPEAT_DELAY  = 12500000,
  parameter int REPEAT_PERIOD = 2500000,
  parameter int CNT_W         = 24
) (
  input  logic              i_Clk,
  input  logic              i_Rst_L,
  input  logic [NUM_SW-1:0] i_Switches,
  input  logic              i_Repeat_En,
  output logic [NUM_SW-1:0] o_Press,
  output logic [NUM_SW-1:0] o_Release,
  output logic [NUM_SW-1:0] o_Held,
  output logic              o_Any_Press
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] DELAY_MAX  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PERIOD_MAX = CNT_W'(REPEAT_PERIOD - 1);

  state_t           r_State [NUM_SW];
  logic [CNT_W-1:0] r_Cnt   [NUM_SW];
  logic [NUM_SW-1:0] r_Prev;
  logic             r_Armed;

  // The first edge after reset only captures the switch levels, so a switch held
  // through reset is treated as already down and never produces a press.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_Armed   <= 1'b0;
      r_Prev    <= '0;
      o_Press   <= '0;
      o_Release <= '0;
      o_Held    <= '0;
      for (int i = 0; i < NUM_SW; i++) begin
        r_State[i] <= IDLE;
        r_Cnt[i]   <= '0;
      end
    end else if (!r_Armed) begin
      r_Armed   <= 1'b1;
      r_Prev    <= i_Switches;
      o_Press   <= '0;
      o_Release <= '0;
    end else begin
      r_Prev <= i_Switches;
      for (int i = 0; i < NUM_SW; i++) begin
        o_Press[i]   <= 1'b0;
        o_Release[i] <= 1'b0;
        case (r_State[i])
          IDLE: begin
            if (i_Switches[i] && !r_Prev[i]) begin
              o_Press[i] <= 1'b1;
              o_Held[i]  <= 1'b1;
              r_State[i] <= DELAY;
              r_Cnt[i]   <= '0;
            end
          end
          DELAY, REPEAT: begin
            // Release wins over a repeat pulse due on the same edge.
            if (!i_Switches[i]) begin
              o_Release[i] <= 1'b1;
              o_Held[i]    <= 1'b0;
              r_State[i]   <= IDLE;
              r_Cnt[i]     <= '0;
            end else if (!i_Repeat_En) begin
              r_Cnt[i] <= '0;
            end else if (r_Cnt[i] == ((r_State[i] == DELAY) ? DELAY_MAX : PERIOD_MAX)) begin
              o_Press[i] <= 1'b1;
              r_State[i] <= REPEAT;
              r_Cnt[i]   <= '0;
            end else begin
              r_Cnt[i] <= r_Cnt[i] + CNT_W'(1);
            end
          end
          default: begin
            o_Held[i]  <= 1'b0;
            r_State[i] <= IDLE;
            r_Cnt[i]   <= '0;
          end
        endcase
      end
    end
  end

  assign o_Any_Press = |o_Press;

endmodule
